// File: rtl/collision_scheduler.sv
// Sweeps every unordered pair of active object slots through an external
// collision detector and queues each colliding pair in a small event FIFO.
module collision_scheduler #(
  parameter int N_OBJ      = 8,
  parameter int DET_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                       Clk,
  input  logic                                       Reset,
  input  logic                                       start,
  input  logic [N_OBJ-1:0]                           obj_active,
  output logic [$clog2(N_OBJ)-1:0]                   idx_a,
  output logic [$clog2(N_OBJ)-1:0]                   idx_b,
  input  logic                                       is_collision,
  output logic                                       busy,
  output logic                                       done,
  output logic [$clog2(N_OBJ*(N_OBJ-1)/2+1)-1:0]     coll_count,
  output logic                                       ev_valid,
  input  logic                                       ev_ready,
  output logic [$clog2(N_OBJ)-1:0]                   ev_a,
  output logic [$clog2(N_OBJ)-1:0]                   ev_b
);

  localparam int IW  = $clog2(N_OBJ);
  localparam int CCW = $clog2(N_OBJ*(N_OBJ-1)/2+1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH+1);

  localparam logic [IW-1:0]  LAST_A    = IW'(N_OBJ-2);
  localparam logic [IW-1:0]  LAST_B    = IW'(N_OBJ-1);
  localparam logic [FCW-1:0] DEPTH_C   = FCW'(FIFO_DEPTH);
  localparam logic [PW-1:0]  LAST_PTR  = PW'(FIFO_DEPTH-1);
  localparam logic [2:0]     WAIT_INIT = 3'((DET_LAT > 0) ? DET_LAT-1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    STALL,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [N_OBJ-1:0] mask_q, mask_d;
  logic [IW-1:0]    idx_a_q, idx_a_d;
  logic [IW-1:0]    idx_b_q, idx_b_d;
  logic [2:0]       wait_q, wait_d;
  logic [CCW-1:0]   coll_q, coll_d;

  logic [2*IW-1:0]  mem_q [FIFO_DEPTH];
  logic [2*IW-1:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [FCW-1:0]   cnt_q, cnt_d;

  logic pair_active;
  logic last_pair;
  logic pop;
  logic space;
  logic push;
  logic pair_done;
  logic accept;

  assign pair_active = mask_q[idx_a_q] & mask_q[idx_b_q];
  assign last_pair   = (idx_a_q == LAST_A) && (idx_b_q == LAST_B);
  assign pop         = (cnt_q != '0) && ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign space       = (cnt_q < DEPTH_C) || pop;
  assign accept      = (state_q == IDLE) && start;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    pair_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!pair_active) begin
          pair_done = 1'b1;
        end else if (DET_LAT == 0) begin
          state_d = CAPTURE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!is_collision) begin
          pair_done = 1'b1;
        end else if (space) begin
          push      = 1'b1;
          pair_done = 1'b1;
        end else begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (space) begin
          push      = 1'b1;
          pair_done = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (pair_done) begin
      state_d = last_pair ? DONE : ISSUE;
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ISSUE, WAIT, CAPTURE, STALL: busy = 1'b1;
      DONE:                        done = 1'b1;
      default: ;
    endcase
  end

  // Pair walk: b runs up to the last slot, then a steps and b restarts at a+1.
  always_comb begin
    mask_d  = mask_q;
    idx_a_d = idx_a_q;
    idx_b_d = idx_b_q;
    coll_d  = coll_q;
    wait_d  = wait_q;
    if (accept) begin
      mask_d  = obj_active;
      coll_d  = '0;
      idx_a_d = '0;
      idx_b_d = IW'(1);
    end
    if (pair_done && !last_pair) begin
      if (idx_b_q == LAST_B) begin
        idx_a_d = idx_a_q + IW'(1);
        idx_b_d = idx_a_q + IW'(2);
      end else begin
        idx_b_d = idx_b_q + IW'(1);
      end
    end
    if (push) begin
      coll_d = coll_q + CCW'(1);
    end
    if (state_q == ISSUE) begin
      wait_d = WAIT_INIT;
    end else if ((state_q == WAIT) && (wait_q != '0)) begin
      wait_d = wait_q - 3'd1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = {idx_a_q, idx_b_q};
      wr_d        = (wr_q == LAST_PTR) ? '0 : wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + FCW'(1);
      2'b01:   cnt_d = cnt_q - FCW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mask_q  <= '0;
      idx_a_q <= '0;
      idx_b_q <= '0;
      wait_q  <= '0;
      coll_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mask_q  <= mask_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      wait_q  <= wait_d;
      coll_q  <= coll_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  assign idx_a        = idx_a_q;
  assign idx_b        = idx_b_q;
  assign coll_count   = coll_q;
  assign ev_valid     = (cnt_q != '0);
  assign {ev_a, ev_b} = mem_q[rd_q];

endmodule

// File: tb/tb_collision_scheduler.sv
// Randomized bench for collision_scheduler: a table-driven detector model feeds
// the DUT, and expected events/timing are derived from the pair-sweep rules.
module tb_collision_scheduler;

  localparam int FIFO_DEPTH = 4;

  logic       Clk;
  logic       Reset;
  logic       start;
  logic [7:0] obj_active;
  logic [2:0] idx_a;
  logic [2:0] idx_b;
  logic       is_collision;
  logic       busy;
  logic       done;
  logic [4:0] coll_count;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_a;
  logic [2:0] ev_b;

  logic [7:0] tbl [8];
  logic       det_q = 1'b0;
  logic [5:0] exp_q [$];

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic       s_done;
  logic       s_busy;
  logic       s_valid;
  logic [2:0] s_idx_a;
  logic [2:0] s_idx_b;
  logic [4:0] s_cnt;
  bit         ev_seen;

  collision_scheduler #(
    .N_OBJ(8),
    .DET_LAT(1),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .start(start),
    .obj_active(obj_active),
    .idx_a(idx_a),
    .idx_b(idx_b),
    .is_collision(is_collision),
    .busy(busy),
    .done(done),
    .coll_count(coll_count),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_a(ev_a),
    .ev_b(ev_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Registered detector with one cycle of latency, looked up from the pair table.
  always @(posedge Clk) det_q <= tbl[idx_a][idx_b];
  assign is_collision = det_q;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total_cnt++;
    if (observed != expected) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic pickReady(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  // One clock: drive at the falling edge, sample mid-low-phase, score any pop.
  task automatic sampleCycle(input logic st, input logic rdy);
    logic [5:0] head;
    start    = st;
    ev_ready = rdy;
    #2;
    s_done  = done;
    s_busy  = busy;
    s_valid = ev_valid;
    s_idx_a = idx_a;
    s_idx_b = idx_b;
    s_cnt   = coll_count;
    if (ev_valid) ev_seen = 1'b1;
    if (ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", 1, 0);
      end else begin
        head = exp_q.pop_front();
        checkOutput("event_pair", int'({ev_a, ev_b}), int'(head));
      end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic applyStimulus(input logic [7:0] mask, input int mode, input int hold,
                               input bit drain);
    logic [5:0] new_ev [$];
    logic [5:0] stall_pair;
    int  exp_k;
    int  done_k;
    bit  busy_ok;
    bit  was_empty;
    logic [4:0] cnt_at_done;
    logic       busy_at_done;
    exp_k = 1;
    for (int a = 0; a < 7; a++) begin
      for (int b = a + 1; b < 8; b++) begin
        if (mask[a] && mask[b]) begin
          exp_k += 3;
          if (tbl[a][b]) new_ev.push_back(6'(a * 8 + b));
        end else begin
          exp_k += 1;
        end
      end
    end
    was_empty  = (exp_q.size() == 0);
    obj_active = mask;
    sampleCycle(1'b1, pickReady(mode));
    foreach (new_ev[i]) exp_q.push_back(new_ev[i]);
    done_k       = 0;
    busy_ok      = 1'b1;
    ev_seen      = 1'b0;
    cnt_at_done  = '0;
    busy_at_done = 1'b1;
    for (int k = 1; k <= 3000 && done_k == 0; k++) begin
      sampleCycle(1'b0, (k <= hold) ? 1'b0 : pickReady(mode));
      if (k == 1) checkOutput("coll_clear", int'(s_cnt), 0);
      if (hold > 0 && k == hold && was_empty && new_ev.size() > FIFO_DEPTH) begin
        stall_pair = new_ev[FIFO_DEPTH];
        checkOutput("stall_idx_a", int'(s_idx_a), int'(stall_pair[5:3]));
        checkOutput("stall_idx_b", int'(s_idx_b), int'(stall_pair[2:0]));
        checkOutput("stall_busy", int'(s_busy), 1);
      end
      if (s_done) begin
        done_k       = k;
        cnt_at_done  = s_cnt;
        busy_at_done = s_busy;
      end else if (!s_busy) begin
        busy_ok = 1'b0;
      end
    end
    checkOutput("done_seen", int'(done_k != 0), 1);
    checkOutput("busy_during_sweep", int'(busy_ok), 1);
    checkOutput("busy_low_at_done", int'(busy_at_done), 0);
    checkOutput("coll_count", int'(cnt_at_done), new_ev.size());
    if (mode == 1 && hold == 0) checkOutput("done_cycle", done_k, exp_k);
    if (was_empty && new_ev.size() == 0) checkOutput("no_ev_valid", int'(ev_seen), 0);
    sampleCycle(1'b0, pickReady(mode));
    checkOutput("done_single", int'(s_done), 0);
    checkOutput("coll_stable", int'(s_cnt), new_ev.size());
    if (drain) begin
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) sampleCycle(1'b0, 1'b1);
      checkOutput("drain_empty", exp_q.size(), 0);
      sampleCycle(1'b0, 1'b0);
      checkOutput("ev_valid_empty", int'(s_valid), 0);
    end
  endtask

  task automatic setTable(input logic [7:0] fill);
    for (int a = 0; a < 8; a++) tbl[a] = fill;
  endtask

  initial begin
    bit found;
    bit saw_done;
    Reset      = 1'b1;
    start      = 1'b0;
    ev_ready   = 1'b0;
    obj_active = '0;
    setTable(8'h00);
    @(negedge Clk);
    @(negedge Clk);
    #1;
    checkOutput("rst_idx_a", int'(idx_a), 0);
    checkOutput("rst_idx_b", int'(idx_b), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_coll", int'(coll_count), 0);
    checkOutput("rst_valid", int'(ev_valid), 0);
    @(negedge Clk);
    Reset = 1'b0;

    $display("[TB] full mask, no collisions");
    applyStimulus(8'hFF, 1, 0, 1'b1);

    $display("[TB] collisions only at (0,1) and (2,5)");
    setTable(8'h00);
    tbl[0][1] = 1'b1;
    tbl[2][5] = 1'b1;
    applyStimulus(8'hFF, 1, 0, 1'b1);

    $display("[TB] every pair collides, consumer stalled then released");
    setTable(8'hFF);
    applyStimulus(8'hFF, 1, 30, 1'b1);

    $display("[TB] only slots 0 and 1 active");
    applyStimulus(8'b0000_0011, 1, 0, 1'b1);

    $display("[TB] reset in the middle of a sweep");
    setTable(8'h00);
    tbl[0][2]  = 1'b1;
    tbl[1][2]  = 1'b1;
    obj_active = 8'hFF;
    sampleCycle(1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      sampleCycle(1'b0, 1'b0);
      if (s_idx_a == 3'd1 && s_idx_b == 3'd3) found = 1'b1;
    end
    checkOutput("rst_reach_pair", int'(found), 1);
    checkOutput("rst_pre_count", int'(s_cnt), 2);
    checkOutput("rst_pre_valid", int'(s_valid), 1);
    Reset = 1'b1;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_coll", int'(coll_count), 0);
    checkOutput("midrst_valid", int'(ev_valid), 0);
    checkOutput("midrst_idx_a", int'(idx_a), 0);
    checkOutput("midrst_idx_b", int'(idx_b), 0);
    exp_q.delete();
    @(posedge Clk);
    @(negedge Clk);
    Reset    = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      sampleCycle(1'b0, 1'b1);
      if (s_done) saw_done = 1'b1;
    end
    checkOutput("no_done_after_rst", int'(saw_done), 0);

    $display("[TB] randomized sweeps");
    for (int it = 0; it < 12; it++) begin
      for (int a = 0; a < 8; a++) tbl[a] = 8'($urandom & $urandom);
      applyStimulus(8'($urandom), int'($urandom_range(1, 2)), 0, 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 200 && exp_q.size() > 0; k++) sampleCycle(1'b0, 1'b1);
    checkOutput("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
